// File: rtl/id_char_pkg.sv
// Character classification shared by the identifier recognizer and its consumers.
package id_char_pkg;

  typedef enum logic [1:0] {
    CLS_O = 2'd0,
    CLS_L = 2'd1,
    CLS_D = 2'd2
  } char_cls_e;

  localparam logic [7:0] CH_LC_LO = 8'h61;  // 'a'
  localparam logic [7:0] CH_LC_HI = 8'h7A;  // 'z'
  localparam logic [7:0] CH_UC_LO = 8'h41;  // 'A'
  localparam logic [7:0] CH_UC_HI = 8'h5A;  // 'Z'
  localparam logic [7:0] CH_DG_LO = 8'h30;  // '0'
  localparam logic [7:0] CH_DG_HI = 8'h39;  // '9'

  function automatic char_cls_e char_class(input logic [7:0] c);
    if ((c >= CH_LC_LO && c <= CH_LC_HI) || (c >= CH_UC_LO && c <= CH_UC_HI))
      return CLS_L;
    else if (c >= CH_DG_LO && c <= CH_DG_HI)
      return CLS_D;
    else
      return CLS_O;
  endfunction

endpackage

// File: rtl/id_len_fifo.sv
// Small synchronous FIFO of token lengths, drained by the host via valid/ready.
// Head data reads as 0 while empty; pointers carry one extra wrap bit.
module id_len_fifo #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [LEN_W-1:0] i_push_data,
  output logic             o_full,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LEN_W-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [LEN_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_wr_en;

  assign o_valid = (r_wr_ptr != r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = o_valid && i_ready;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_wr_en = i_push && (!o_full || w_pop);
  assign o_data  = o_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/id_token_stats.sv
// Measures and counts letters-then-digits tokens seen alongside the identifier recognizer.
// Optional longest-token register is built only when ID_STATS_EN is defined.
module id_token_stats
  import id_char_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i_char,
  input  logic             i_match,
  output logic             o_tok_done,
  output logic [CNT_W-1:0] o_tok_count,
  output logic             o_len_valid,
  output logic [LEN_W-1:0] o_len_data,
  input  logic             i_len_ready,
  output logic             o_len_ovf,
  output logic [LEN_W-1:0] o_max_len
);

  char_cls_e        w_cls;
  logic             w_complete;
  logic             w_full;
  logic             w_drop;
  logic [LEN_W-1:0] w_seg_inc;
  logic [LEN_W-1:0] w_seg_next;
  logic             w_armed_next;

  logic [LEN_W-1:0] r_seg_len;
  logic             r_prev_d;
  logic             r_armed;
  logic             r_tok_done;
  logic [CNT_W-1:0] r_tok_count;
  logic             r_len_ovf;

  assign w_cls      = char_class(i_char);
  // armed masks stale matches from the recognizer, which keeps running through reset.
  assign w_complete = i_match && (w_cls != CLS_D) && r_armed;
  assign w_drop     = w_complete && w_full && !(o_len_valid && i_len_ready);
  assign w_seg_inc  = (r_seg_len == '1) ? r_seg_len : r_seg_len + LEN_W'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_seg_next   = '0;
    w_armed_next = r_armed;
    unique case (w_cls)
      CLS_L: begin
        w_seg_next   = r_prev_d ? LEN_W'(1) : w_seg_inc;
        w_armed_next = 1'b1;
      end
      CLS_D: begin
        w_seg_next = (r_seg_len != '0) ? w_seg_inc : '0;
        if (w_complete) w_armed_next = 1'b0;
      end
      default: begin
        w_seg_next   = '0;
        w_armed_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_len   <= '0;
      r_prev_d    <= 1'b0;
      r_armed     <= 1'b0;
      r_tok_done  <= 1'b0;
      r_tok_count <= '0;
      r_len_ovf   <= 1'b0;
    end else begin
      r_seg_len  <= w_seg_next;
      r_prev_d   <= (w_cls == CLS_D);
      r_armed    <= w_armed_next;
      r_tok_done <= w_complete;
      if (w_complete) r_tok_count <= r_tok_count + CNT_W'(1);
      if (w_drop)     r_len_ovf   <= 1'b1;
    end
  end

  id_len_fifo #(
    .LEN_W (LEN_W),
    .DEPTH (DEPTH)
  ) u_len_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_complete),
    .i_push_data (r_seg_len),
    .o_full      (w_full),
    .o_valid     (o_len_valid),
    .i_ready     (i_len_ready),
    .o_data      (o_len_data)
  );

  assign o_tok_done  = r_tok_done;
  assign o_tok_count = r_tok_count;
  assign o_len_ovf   = r_len_ovf;

`ifdef ID_STATS_EN
  logic [LEN_W-1:0] r_max_len;

  // Dropped lengths still count toward the maximum.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_max_len <= '0;
    else if (w_complete && (r_seg_len > r_max_len))
      r_max_len <= r_seg_len;
  end

  assign o_max_len = r_max_len;
`else
  assign o_max_len = '0;
`endif

endmodule

// File: tb/tb_id_token_stats.sv
// Directed bench for id_token_stats with a reset-less recognizer model driving match.
module tb_id_token_stats;

  localparam int LEN_W = 8;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;

`ifdef ID_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       i_char = 8'h31;
  logic             i_match;
  logic             o_tok_done;
  logic [CNT_W-1:0] o_tok_count;
  logic             o_len_valid;
  logic [LEN_W-1:0] o_len_data;
  logic             i_len_ready = 1'b0;
  logic             o_len_ovf;
  logic [LEN_W-1:0] o_max_len;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  id_token_stats #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_char      (i_char),
    .i_match     (i_match),
    .o_tok_done  (o_tok_done),
    .o_tok_count (o_tok_count),
    .o_len_valid (o_len_valid),
    .o_len_data  (o_len_data),
    .i_len_ready (i_len_ready),
    .o_len_ovf   (o_len_ovf),
    .o_max_len   (o_max_len)
  );

  // Recognizer model: Moore FSM with no reset, starting in the matching state.
  typedef enum logic [1:0] {R_IDLE, R_LET, R_DIG} rec_e;
  rec_e rec_q = R_DIG;

  function automatic bit is_let(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A);
  endfunction

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39);
  endfunction

  always @(posedge clk) begin
    if (is_let(i_char))
      rec_q <= R_LET;
    else if (is_dig(i_char))
      rec_q <= (rec_q == R_IDLE) ? R_IDLE : R_DIG;
    else
      rec_q <= R_IDLE;
  end

  assign i_match = (rec_q == R_DIG);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] c);
    rst_n       = 1'b0;
    i_char      = c;
    i_len_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drive one char per cycle; pattern holds the expected tok_done after each edge.
  task automatic send(input string s, input string pat);
    for (int i = 0; i < s.len(); i++) begin
      i_char = s[i];
      @(posedge clk); #1;
      check($sformatf("tok_done[%0d]", i), {31'b0, o_tok_done}, {31'b0, pat[i] == 8'h31});
    end
  endtask

  // Pop every queued expectation from the DUT, then confirm the FIFO is empty.
  task automatic drain();
    int exp_len;
    while (exp_q.size() > 0) begin
      exp_len = exp_q.pop_front();
      check("len_valid", {31'b0, o_len_valid}, 1);
      check("len_data", o_len_data, exp_len);
      i_len_ready = 1'b1;
      @(posedge clk); #1;
      i_len_ready = 1'b0;
    end
    check("fifo_empty", {31'b0, o_len_valid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with the recognizer still asserting match from before.
    do_reset(8'h31);
    check("rst_tok_done", {31'b0, o_tok_done}, 0);
    check("rst_tok_count", o_tok_count, 0);
    check("rst_len_valid", {31'b0, o_len_valid}, 0);
    check("rst_len_data", o_len_data, 0);
    check("rst_len_ovf", {31'b0, o_len_ovf}, 0);
    check("rst_max_len", o_max_len, 0);
    check("stale_match", {31'b0, i_match}, 1);
    send(" ", "0");

    // Single token of length 4; head holds while ready is low.
    exp_q.push_back(4);
    send("ab12 ", "00001");
    check("t1_count", o_tok_count, 1);
    check("t1_valid", {31'b0, o_len_valid}, 1);
    @(posedge clk); #1;
    check("t1_done_clear", {31'b0, o_tok_done}, 0);
    check("t1_stable", o_len_data, 4);
    drain();

    // Two back-to-back tokens.
    do_reset(8'h20);
    exp_q.push_back(2);
    exp_q.push_back(2);
    send("a1b2;", "00101");
    check("t2_count", o_tok_count, 2);
    drain();

    // No completion.
    do_reset(8'h20);
    send("abc;12;", "0000000");
    check("t3_count", o_tok_count, 0);
    check("t3_valid", {31'b0, o_len_valid}, 0);

    // Fill, pop+push at full, then overflow.
    do_reset(8'h20);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(2);
      send("x1 ", "001");
    end
    check("t4_full_ovf", {31'b0, o_len_ovf}, 0);
    check("t4_full_count", o_tok_count, DEPTH);
    send("xy1", "000");
    check("t4_head", o_len_data, exp_q.pop_front());
    exp_q.push_back(3);
    i_char      = 8'h20;
    i_len_ready = 1'b1;
    @(posedge clk); #1;
    i_len_ready = 1'b0;
    check("t4_popush_done", {31'b0, o_tok_done}, 1);
    check("t4_popush_ovf", {31'b0, o_len_ovf}, 0);
    send("x1 ", "001");
    check("t4_ovf", {31'b0, o_len_ovf}, 1);
    check("t4_count", o_tok_count, DEPTH + 2);
    drain();
    check("t4_ovf_sticky", {31'b0, o_len_ovf}, 1);

    // Reset mid-token: the tail after reset must not complete.
    do_reset(8'h20);
    send("ab", "00");
    do_reset(8'h31);
    check("t5_count_rst", o_tok_count, 0);
    send("2 ", "00");
    check("t5_count", o_tok_count, 0);
    check("t5_valid", {31'b0, o_len_valid}, 0);

    // Saturating length.
    do_reset(8'h20);
    exp_q.push_back(255);
    i_char = 8'h61;
    repeat (300) @(posedge clk);
    #1;
    send("1 ", "01");
    drain();

    // Longest-token statistic.
    do_reset(8'h20);
    check("t6_max_rst", o_max_len, 0);
    exp_q.push_back(3);
    send("ab1 ", "0001");
    check("t6_max_a", o_max_len, STATS ? 3 : 0);
    exp_q.push_back(7);
    send("abcdef1 ", "00000001");
    check("t6_max_b", o_max_len, STATS ? 7 : 0);
    exp_q.push_back(2);
    send("a1 ", "001");
    check("t6_max_c", o_max_len, STATS ? 7 : 0);
    check("t6_count", o_tok_count, 3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
